// File: rtl/da_sample_feeder_if.sv
// -----------------------------------------------------------------------------
// da_sample_feeder_if
//   Sample-in / slice-out bundle for the distributed-arithmetic input feeder.
//
//   Parameters
//     WORD_WIDTH : sample width in bits
//     BAAT       : bits per emitted slice
//
//   Signals
//     s_valid, s_data, s_ready : parallel-sample valid/ready handshake
//     en                       : downstream advance (consumes a shown slice)
//     slice_valid, slice_out   : current slice, MSB (sign) slice first
//     slice_first, slice_last  : slice position flags (bank x_we / ts)
//     busy                     : a sample is in flight or buffered
//
//   Modports
//     master : the feeder (transmitting end of the slice stream)
//     slave  : the environment (sample source and slice consumer)
// -----------------------------------------------------------------------------
interface da_sample_feeder_if #(
    parameter int WORD_WIDTH = 16,
    parameter int BAAT       = 4
);
    logic                  s_valid;
    logic                  s_ready;
    logic [WORD_WIDTH-1:0] s_data;
    logic                  en;
    logic                  slice_valid;
    logic [BAAT-1:0]       slice_out;
    logic                  slice_first;
    logic                  slice_last;
    logic                  busy;

    modport master (
        input  s_valid, s_data, en,
        output s_ready, slice_valid, slice_out, slice_first, slice_last, busy
    );

    modport slave (
        output s_valid, s_data, en,
        input  s_ready, slice_valid, slice_out, slice_first, slice_last, busy
    );
endinterface

// File: rtl/da_sample_feeder.sv
// -----------------------------------------------------------------------------
// da_sample_feeder
//   Accepts parallel two's-complement samples over valid/ready and serializes
//   each one into NSLICE = WORD_WIDTH/BAAT slices of BAAT bits, MSB (sign)
//   slice first, with first/last flags for the subfilter bank.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous reset, active low
//     bus  : da_sample_feeder_if.master (sample handshake + slice stream)
//
//   Build option
//     DA_FEEDER_SKID_EN : when defined, adds a one-entry holding buffer so the
//                         next sample can be posted at any point during a
//                         shift; s_ready then means "buffer not full".
//                         When undefined, s_ready is only high in IDLE or on
//                         the cycle the last slice is consumed.
//
//   All outputs except s_ready come straight from flops.
// -----------------------------------------------------------------------------
module da_sample_feeder #(
    parameter int WORD_WIDTH = 16,
    parameter int BAAT       = 4
) (
    input  logic              clk,
    input  logic              rst,
    da_sample_feeder_if.master bus
);
    localparam int NSLICE = WORD_WIDTH / BAAT;
    // Keep the counter at least one bit wide so NSLICE==1 still elaborates.
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

    generate
        if (WORD_WIDTH % BAAT != 0) begin : g_bad_baat
            $error("da_sample_feeder: WORD_WIDTH must be a multiple of BAAT");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  slice_valid_q;
    logic [BAAT-1:0]       slice_out_q;
    logic                  slice_first_q;
    logic                  slice_last_q;
    logic                  busy_q;

    logic                  accept;
    logic                  consume;
    logic                  at_last;
    logic                  buf_full_d;

`ifdef DA_FEEDER_SKID_EN
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q;

    // One free slot is all the upstream needs to see.
    assign bus.s_ready = rst & ~buf_full_q;
`else
    // No storage: only take a sample when the shift register is free now or
    // frees up at this edge (last slice consumed), which gives zero bubble.
    assign bus.s_ready = rst & ((state_q == IDLE) | (slice_last_q & bus.en));
    assign buf_full_d  = 1'b0;
`endif

    assign accept  = bus.s_valid & bus.s_ready;
    assign consume = (state_q == SHIFT) & bus.en;
    assign at_last = (cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef DA_FEEDER_SKID_EN
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = bus.s_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (consume && !at_last) begin
                    sr_d  = sr_q << BAAT;
                    cnt_d = cnt_q + CW'(1);
                end else if (consume) begin
`ifdef DA_FEEDER_SKID_EN
                    // A buffered sample always goes ahead of a new one; the
                    // buffer is full here so s_ready is low and nothing new
                    // can arrive this cycle.
                    if (buf_full_q) begin
                        sr_d       = buf_q;
                        cnt_d      = '0;
                        buf_full_d = 1'b0;
                    end else if (accept) begin
                        sr_d  = bus.s_data;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    if (accept) begin
                        sr_d  = bus.s_data;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
`ifdef DA_FEEDER_SKID_EN
                // Anything accepted while not loading directly is parked.
                if (accept && !(consume && at_last)) begin
                    buf_d      = bus.s_data;
                    buf_full_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            cnt_q         <= '0;
            slice_valid_q <= 1'b0;
            slice_out_q   <= '0;
            slice_first_q <= 1'b0;
            slice_last_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            // Outputs are precomputed from next-state so they line up with
            // the state register; en=0 leaves next==current and holds them.
            slice_valid_q <= (state_d == SHIFT);
            slice_out_q   <= (state_d == SHIFT) ? sr_d[WORD_WIDTH-1 -: BAAT] : '0;
            slice_first_q <= (state_d == SHIFT) && (cnt_d == '0);
            slice_last_q  <= (state_d == SHIFT) && (cnt_d == CNT_LAST);
            busy_q        <= (state_d == SHIFT) | buf_full_d;
        end
    end

`ifdef DA_FEEDER_SKID_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end
`endif

    assign bus.slice_valid = slice_valid_q;
    assign bus.slice_out   = slice_out_q;
    assign bus.slice_first = slice_first_q;
    assign bus.slice_last  = slice_last_q;
    assign bus.busy        = busy_q;

endmodule
